// File: rtl/axi4_pkg.sv
// Shared AXI4 slave definitions: bus widths, response codes, FSM state types
// and the address-decode helper used by both the write and read channels.
package axi4_pkg;

   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   // Range check uses the wrapped offset, so addresses below base fall out of range too.
   function automatic logic [1:0] decode_resp(input logic [ADDR_W-1:0] addr,
                                              input logic [ADDR_W-1:0] base,
                                              input logic [ADDR_W-1:0] depth_words);
      logic [ADDR_W-1:0] offset;
      logic [1:0]        resp;
      offset = addr - base;
      if ({2'b00, offset[ADDR_W-1:2]} >= depth_words) begin
         resp = RESP_DECERR;
      end else if (addr[1:0] != 2'b00) begin
         resp = RESP_SLVERR;
      end else begin
         resp = RESP_OKAY;
      end
      return resp;
   endfunction

endpackage

// File: rtl/axi4_dmem_slave_if.sv
// Single-beat AXI4 bus bundle between a master and the data-memory slave.
interface axi4_dmem_slave_if;
   import axi4_pkg::*;

   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic [ID_W-1:0]   awid;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic [ID_W-1:0]   bid;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [ID_W-1:0]   arid;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [ID_W-1:0]   rid;

   modport slave (
      input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arid, rready,
      output awready, wready, bvalid, bresp, bid,
             arready, rvalid, rdata, rresp, rlast, rid
   );

   modport master (
      output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
             arvalid, araddr, arid, rready,
      input  awready, wready, bvalid, bresp, bid,
             arready, rvalid, rdata, rresp, rlast, rid
   );

endinterface

// File: rtl/axi4_slave_mem.sv
// Synchronous word RAM with byte enables: one write port, one registered read port, no reset.
module axi4_slave_mem
   import axi4_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

   // Same-edge read of a word being written returns the old contents.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (wstrb[b]) begin
               mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/axi4_dmem_slave.sv
// Single-beat AXI4 data-memory slave: independent write and read FSMs sharing
// a byte-enable RAM, with OKAY/SLVERR/DECERR address decode.
module axi4_dmem_slave
   import axi4_pkg::*;
#(
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000
) (
   input logic              clk,
   input logic              rst,
   axi4_dmem_slave_if.slave bus
);

   localparam int unsigned       MEM_AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

   w_state_t          w_state_r, w_state_s;
   r_state_t          r_state_r, r_state_s;
   logic              aw_latched_r, w_latched_r;
   logic [ADDR_W-1:0] awaddr_r;
   logic [ID_W-1:0]   awid_r;
   logic [DATA_W-1:0] wdata_r;
   logic [STRB_W-1:0] wstrb_r;
   logic              awready_r, wready_r, arready_r;
   logic [1:0]        bresp_r, rresp_r;
   logic [ID_W-1:0]   bid_r, rid_r;
   logic              rd_ok_r;
   logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s, mem_we_s;
   logic [1:0]        wr_resp_s, rd_resp_s;
   logic [MEM_AW-1:0] wr_idx_s, rd_idx_s;
   logic [DATA_W-1:0] mem_rdata_s;

   assign aw_hs_s   = bus.awvalid && awready_r;
   assign w_hs_s    = bus.wvalid && wready_r;
   assign b_hs_s    = (w_state_r == W_RESP) && bus.bready;
   assign ar_hs_s   = bus.arvalid && arready_r;
   assign r_hs_s    = (r_state_r == R_DATA) && bus.rready;
   assign commit_s  = (w_state_r == W_IDLE) && aw_latched_r && w_latched_r;
   assign wr_resp_s = decode_resp(awaddr_r, BASE_ADDR, DEPTH_L);
   assign rd_resp_s = decode_resp(bus.araddr, BASE_ADDR, DEPTH_L);
   assign mem_we_s  = commit_s && (wr_resp_s == RESP_OKAY);
   assign wr_idx_s  = MEM_AW'((awaddr_r - BASE_ADDR) >> 2'd2);
   assign rd_idx_s  = MEM_AW'((bus.araddr - BASE_ADDR) >> 2'd2);

   // Write FSM next state.
   always_comb begin
      w_state_s = w_state_r;
      case (w_state_r)
         W_IDLE:  if (commit_s) w_state_s = W_RESP; else w_state_s = W_IDLE;
         W_RESP:  if (b_hs_s)   w_state_s = W_IDLE; else w_state_s = W_RESP;
         default: w_state_s = W_IDLE;
      endcase
   end

   // Read FSM next state.
   always_comb begin
      r_state_s = r_state_r;
      case (r_state_r)
         R_IDLE:  if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
         R_DATA:  if (r_hs_s)  r_state_s = R_IDLE; else r_state_s = R_DATA;
         default: r_state_s = R_IDLE;
      endcase
   end

   // FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_r <= W_IDLE;
         r_state_r <= R_IDLE;
      end else begin
         w_state_r <= w_state_s;
         r_state_r <= r_state_s;
      end
   end

   // Write channel: each of AW/W is captured on its own handshake and its ready held low until B completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_latched_r <= 1'b0;
         w_latched_r  <= 1'b0;
         awaddr_r     <= 32'h0000_0000;
         awid_r       <= 4'h0;
         wdata_r      <= 32'h0000_0000;
         wstrb_r      <= 4'h0;
         awready_r    <= 1'b1;
         wready_r     <= 1'b1;
         bresp_r      <= 2'b00;
         bid_r        <= 4'h0;
      end else begin
         if (aw_hs_s) begin
            aw_latched_r <= 1'b1;
            awaddr_r     <= bus.awaddr;
            awid_r       <= bus.awid;
            awready_r    <= 1'b0;
         end
         if (w_hs_s) begin
            w_latched_r <= 1'b1;
            wdata_r     <= bus.wdata;
            wstrb_r     <= bus.wstrb;
            wready_r    <= 1'b0;
         end
         if (commit_s) begin
            aw_latched_r <= 1'b0;
            w_latched_r  <= 1'b0;
            bresp_r      <= wr_resp_s;
            bid_r        <= awid_r;
         end
         if (b_hs_s) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
         end
      end
   end

   // Read channel: response fields are captured with the RAM sample and held until R completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arready_r <= 1'b1;
         rresp_r   <= 2'b00;
         rid_r     <= 4'h0;
         rd_ok_r   <= 1'b0;
      end else begin
         if (ar_hs_s) begin
            arready_r <= 1'b0;
            rresp_r   <= rd_resp_s;
            rid_r     <= bus.arid;
            rd_ok_r   <= (rd_resp_s == RESP_OKAY);
         end
         if (r_hs_s) begin
            arready_r <= 1'b1;
            rd_ok_r   <= 1'b0;
         end
      end
   end

   axi4_slave_mem #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (MEM_AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (wr_idx_s),
      .wdata (wdata_r),
      .wstrb (wstrb_r),
      .re    (ar_hs_s),
      .raddr (rd_idx_s),
      .rdata (mem_rdata_s)
   );

   assign bus.awready = awready_r;
   assign bus.wready  = wready_r;
   assign bus.bvalid  = (w_state_r == W_RESP);
   assign bus.bresp   = bresp_r;
   assign bus.bid     = bid_r;
   assign bus.arready = arready_r;
   assign bus.rvalid  = (r_state_r == R_DATA);
   assign bus.rlast   = (r_state_r == R_DATA);
   assign bus.rresp   = rresp_r;
   assign bus.rid     = rid_r;
   // Error responses and idle periods present zero data; the RAM register itself is never reset.
   assign bus.rdata   = rd_ok_r ? mem_rdata_s : 32'h0000_0000;

endmodule
